// File: rtl/bufcnt_pkg.sv
// ----------------------------------------------------------------------------
// bufcnt_pkg
// Shared definitions for the buffer/counter transfer controller:
//   - default datapath width and SHIFT timeout length
//   - FSM state encoding
//   - control-output bundle and the state -> output decode used by the FSM
// ----------------------------------------------------------------------------
package bufcnt_pkg;

    localparam int W_DEF      = 8;    // width of pi / cfg_len
    localparam int TO_CYC_DEF = 255;  // SHIFT cycles allowed before ERR

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Control outputs that depend only on the FSM state.
    typedef struct packed {
        logic ld;
        logic en_cnt;
        logic en_tri;
        logic busy;
        logic done;
        logic err;
    } ctrl_t;

    // Moore decode: the FSM registers the decode of its next state, so the
    // outputs seen during a cycle are exactly the decode of the current state.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_LOAD: begin
                c.ld   = 1'b1;
                c.busy = 1'b1;
            end
            ST_SHIFT: begin
                c.en_cnt = 1'b1;
                c.en_tri = 1'b1;
                c.busy   = 1'b1;
            end
            ST_DONE: c.done = 1'b1;
            ST_ERR:  c.err  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bufcnt_tmr.sv
// ----------------------------------------------------------------------------
// bufcnt_tmr
// SHIFT-phase cycle counter for the transfer controller.
//   clk      in  clock
//   rst      in  asynchronous active-low reset
//   clr      in  synchronous clear (held while the FSM is outside SHIFT)
//   en       in  count enable (high for every SHIFT cycle)
//   expired  out high during the TO_CYC-th consecutive enabled cycle
//
// The counter holds the number of SHIFT cycles already completed, so during
// the n-th SHIFT cycle it reads n-1. expired therefore rises in the cycle in
// which the TO_CYC-th SHIFT cycle is being spent, letting the FSM leave on
// the edge that ends it.
// ----------------------------------------------------------------------------
module bufcnt_tmr
    import bufcnt_pkg::*;
#(
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            // Saturates at LAST; the FSM leaves SHIFT before it matters.
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/bufcnt_ctrl.sv
// ----------------------------------------------------------------------------
// bufcnt_ctrl
// Control FSM for a buffer/counter datapath. One transfer is:
//   IDLE --start--> LOAD (1 cycle, ld) --> SHIFT (en_cnt/en_tri until co)
//        --> DONE (1-cycle done pulse) --> IDLE
// A SHIFT phase that runs TO_CYC cycles without co goes to ERR, which is
// left only through clr_err. abort returns to IDLE from anywhere.
//
// Ports
//   clk      in  clock, all state changes on its rising edge
//   rst      in  asynchronous active-low reset
//   start    in  transfer request, sampled only in IDLE
//   abort    in  cancel, highest priority
//   clr_err  in  leave ERR
//   cfg_len  in  [W] count preset, latched into pi on an accepted start
//   co       in  datapath carry-out, ends SHIFT
//   ld       out parallel-load strobe (LOAD)
//   en_cnt   out counter/shift enable (SHIFT)
//   en_tri   out serial-output tri-state enable (SHIFT)
//   pi       out [W] parallel-load word
//   busy     out high in LOAD and SHIFT
//   done     out one-cycle completion pulse (DONE)
//   err      out high while in ERR
//
// All control outputs are registered from the next-state decode, so they are
// glitch-free Moore outputs. pi is a data word rather than a strobe: it keeps
// the last latched preset (also across abort) until the next accepted start,
// and only reset clears it.
// ----------------------------------------------------------------------------
module bufcnt_ctrl
    import bufcnt_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         clr_err,
    input  logic [W-1:0] cfg_len,
    input  logic         co,
    output logic         ld,
    output logic         en_cnt,
    output logic         en_tri,
    output logic [W-1:0] pi,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_t state;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   load_pi;
    logic   tmr_en;
    logic   tmr_clr;
    logic   tmr_expired;

    // Counter runs only in SHIFT and is held clear everywhere else, so it is
    // zero on every entry to SHIFT.
    assign tmr_en  = (state == ST_SHIFT);
    assign tmr_clr = (state != ST_SHIFT);

    bufcnt_tmr #(
        .TO_CYC (TO_CYC)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Next-state logic. abort overrides every other input; within SHIFT a
    // carry-out beats a simultaneous timeout.
    // NOTE: nxt gets a default before the case so no path leaves it
    // unassigned, which keeps this block purely combinational (no latch).
    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        nxt = (cfg_len != '0) ? ST_LOAD : ST_DONE;
                    end
                end
                ST_LOAD:  nxt = ST_SHIFT;
                ST_SHIFT: begin
                    if (co) begin
                        nxt = ST_DONE;
                    end else if (tmr_expired) begin
                        nxt = ST_ERR;
                    end
                end
                ST_DONE:  nxt = ST_IDLE;
                ST_ERR: begin
                    if (clr_err) begin
                        nxt = ST_IDLE;
                    end
                end
                default:  nxt = ST_IDLE;
            endcase
        end
    end

    // pi is captured only for a start that actually enters LOAD.
    assign load_pi = (state == ST_IDLE) && start && !abort && (cfg_len != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            ctrl_q <= '0;
            pi     <= '0;
        end else begin
            state  <= nxt;
            ctrl_q <= decode_state(nxt);
            if (load_pi) begin
                pi <= cfg_len;
            end
        end
    end

    assign ld     = ctrl_q.ld;
    assign en_cnt = ctrl_q.en_cnt;
    assign en_tri = ctrl_q.en_tri;
    assign busy   = ctrl_q.busy;
    assign done   = ctrl_q.done;
    assign err    = ctrl_q.err;

endmodule

// File: tb/tb_bufcnt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bufcnt_ctrl
// Self-checking bench for bufcnt_ctrl. Inputs are driven on the falling edge;
// a transaction-level model of the transfer protocol predicts the outputs
// after the following rising edge and pushes them to a scoreboard queue,
// which is popped and compared one time unit after that edge.
// ----------------------------------------------------------------------------
module tb_bufcnt_ctrl;

    localparam int W      = 8;
    localparam int TO_CYC = 255;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic         clr_err;
    logic [W-1:0] cfg_len;
    logic         co;
    logic         ld;
    logic         en_cnt;
    logic         en_tri;
    logic [W-1:0] pi;
    logic         busy;
    logic         done;
    logic         err;

    bufcnt_ctrl #(
        .W      (W),
        .TO_CYC (TO_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .clr_err (clr_err),
        .cfg_len (cfg_len),
        .co      (co),
        .ld      (ld),
        .en_cnt  (en_cnt),
        .en_tri  (en_tri),
        .pi      (pi),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output snapshot: {ld, en_cnt, en_tri, busy, done, err} + pi.
    typedef struct packed {
        logic [5:0]   ctl;
        logic [W-1:0] pi;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_err    = 0;

    // Pulse/cycle tallies observed on the DUT, cleared per scenario.
    int ld_seen;
    int shift_seen;
    int done_seen;
    int err_seen;

    // Reference model of the protocol.
    typedef enum int {M_IDLE, M_LOAD, M_SHIFT, M_DONE, M_ERR} mst_t;
    mst_t         m_st;
    int           m_shifts;   // SHIFT cycles completed in this transfer
    logic [W-1:0] m_pi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [5:0] model_ctl();
        case (m_st)
            M_LOAD:  return 6'b100100;
            M_SHIFT: return 6'b011100;
            M_DONE:  return 6'b000010;
            M_ERR:   return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic model_reset();
        m_st     = M_IDLE;
        m_shifts = 0;
        m_pi     = '0;
    endtask

    task automatic model_advance(input logic s, input logic a, input logic c,
                                 input logic [W-1:0] len, input logic cov);
        if (a) begin
            m_st = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (s) begin
                        if (len != 0) begin
                            m_pi = len;
                            m_st = M_LOAD;
                        end else begin
                            m_st = M_DONE;
                        end
                    end
                end
                M_LOAD: begin
                    m_shifts = 0;
                    m_st     = M_SHIFT;
                end
                M_SHIFT: begin
                    m_shifts++;
                    if (cov)                    m_st = M_DONE;
                    else if (m_shifts >= TO_CYC) m_st = M_ERR;
                end
                M_DONE: m_st = M_IDLE;
                M_ERR:  if (c) m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    task automatic clear_tallies();
        ld_seen    = 0;
        shift_seen = 0;
        done_seen  = 0;
        err_seen   = 0;
    endtask

    // One clock of stimulus: drive, predict, wait for the edge, compare.
    task automatic step(input logic s, input logic a, input logic c,
                        input logic [W-1:0] len, input logic cov, input string tag);
        exp_t e;
        @(negedge clk);
        start   = s;
        abort   = a;
        clr_err = c;
        cfg_len = len;
        co      = cov;
        model_advance(s, a, c, len, cov);
        e.ctl = model_ctl();
        e.pi  = m_pi;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_ctl"}, {ld, en_cnt, en_tri, busy, done, err}, e.ctl);
            check({tag, "_pi"}, pi, e.pi);
        end
        ld_seen    += int'(ld);
        shift_seen += int'(en_cnt);
        done_seen  += int'(done);
        err_seen   += int'(err);
    endtask

    task automatic idle_step(input string tag);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, tag);
    endtask

    initial begin
        start   = 1'b0;
        abort   = 1'b0;
        clr_err = 1'b0;
        cfg_len = '0;
        co      = 1'b0;
        rst     = 1'b1;
        model_reset();
        clear_tallies();

        // Reset state.
        #2 rst = 1'b0;
        #1;
        check("reset_ctl", {ld, en_cnt, en_tri, busy, done, err}, 6'b0);
        check("reset_pi", pi, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // Nominal transfer of length 0x0A; co offered during LOAD must be
        // ignored; start while busy must not queue a second transfer.
        clear_tallies();
        step(1'b1, 1'b0, 1'b0, 8'h0A, 1'b0, "nom_start");
        step(1'b0, 1'b0, 1'b0, 8'h33, 1'b1, "nom_load");
        for (int i = 1; i <= 10; i++) begin
            step((i == 4), 1'b0, 1'b0, 8'h44, (i == 10), "nom_shift");
        end
        idle_step("nom_tail");
        idle_step("nom_tail");
        check("nom_ld_cycles", ld_seen, 1);
        check("nom_shift_cycles", shift_seen, 10);
        check("nom_done_pulses", done_seen, 1);

        // Zero length: straight to DONE, no load strobe, pi keeps 0x0A.
        clear_tallies();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "zero_start");
        idle_step("zero_tail");
        check("zero_ld_cycles", ld_seen, 0);
        check("zero_done_pulses", done_seen, 1);

        // abort wins over start in IDLE: nothing latched.
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, "abort_idle");

        // Abort in the 3rd SHIFT cycle, co asserted alongside to show priority.
        clear_tallies();
        step(1'b1, 1'b0, 1'b0, 8'h05, 1'b0, "ab_start");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "ab_load");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "ab_shift1");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "ab_shift2");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "ab_shift3");
        idle_step("ab_tail");
        check("ab_done_pulses", done_seen, 0);

        // A new transfer after abort is accepted normally.
        clear_tallies();
        step(1'b1, 1'b0, 1'b0, 8'h03, 1'b0, "re_start");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "re_load");
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, (i == 3), "re_shift");
        end
        idle_step("re_tail");
        check("re_done_pulses", done_seen, 1);
        check("re_shift_cycles", shift_seen, 3);

        // Timeout: co never arrives, ERR after TO_CYC SHIFT cycles; start is
        // ignored in ERR and clr_err returns to IDLE.
        clear_tallies();
        step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, "to_start");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "to_load");
        for (int i = 1; i <= TO_CYC; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "to_shift");
        end
        step(1'b1, 1'b0, 1'b0, 8'h12, 1'b0, "to_err_start");
        idle_step("to_err_hold");
        check("to_shift_cycles", shift_seen, TO_CYC);
        check("to_err_cycles", err_seen, 3);
        check("to_done_pulses", done_seen, 0);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, "to_clr");
        idle_step("to_idle");

        // co on the very cycle the timeout fires: co wins.
        clear_tallies();
        step(1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, "tie_start");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "tie_load");
        for (int i = 1; i <= TO_CYC; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, (i == TO_CYC), "tie_shift");
        end
        idle_step("tie_tail");
        check("tie_done_pulses", done_seen, 1);
        check("tie_err_cycles", err_seen, 0);

        // Asynchronous reset mid-SHIFT, between clock edges.
        clear_tallies();
        step(1'b1, 1'b0, 1'b0, 8'h09, 1'b0, "rst_start");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "rst_load");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "rst_shift1");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_ctl", {ld, en_cnt, en_tri, busy, done, err}, 6'b0);
        check("async_rst_pi", pi, 8'h00);
        start   = 1'b1;
        cfg_len = 8'h21;
        @(posedge clk);
        #1;
        check("rst_held_ctl", {ld, en_cnt, en_tri, busy, done, err}, 6'b0);
        @(negedge clk);
        start = 1'b0;
        #1 rst = 1'b1;
        idle_step("post_rst_idle");
        check("rst_done_pulses", done_seen, 0);

        // Resume after reset; start pulse while busy is ignored.
        clear_tallies();
        step(1'b1, 1'b0, 1'b0, 8'h06, 1'b0, "pr_start");
        step(1'b1, 1'b0, 1'b0, 8'h02, 1'b0, "pr_load");
        for (int i = 1; i <= 6; i++) begin
            step((i == 2), 1'b0, 1'b0, 8'h02, (i == 6), "pr_shift");
        end
        idle_step("pr_tail");
        idle_step("pr_tail");
        check("pr_done_pulses", done_seen, 1);
        check("pr_ld_cycles", ld_seen, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/bufcnt_ctrl.md
BUFCNT_CTRL -- requirements
Module: bufcnt_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, the width of the datapath parallel-load word (pi) and of cfg_len.
REQ-002 The block SHALL have parameter TO_CYC, default 255, the maximum SHIFT cycles allowed before a timeout error.
REQ-003 The block SHALL have ports:
  clk      in   1   single clock; all state changes on its rising edge
  rst      in   1   asynchronous, active-low reset
  start    in   1   request one transfer; sampled only in IDLE
  abort    in   1   cancel any operation; return to IDLE
  clr_err  in   1   leave ERR state
  cfg_len  in   W   count preset; latched on an accepted start
  co       in   1   carry-out from the buffer/counter datapath
  ld       out  1   parallel-load strobe to the datapath
  en_cnt   out  1   counter/shift enable to the datapath
  en_tri   out  1   serial-output tri-state enable to the datapath
  pi       out  W   parallel-load word to the datapath
  busy     out  1   high in LOAD and SHIFT
  done     out  1   one-cycle completion pulse
  err      out  1   high while in ERR

Function
REQ-004 The block SHALL be a Moore FSM: every output registered and decoded from the current state only.
REQ-005 States SHALL be IDLE, LOAD, SHIFT, DONE and ERR.
REQ-006 IDLE: start=1 with cfg_len!=0 SHALL latch cfg_len into pi and go to LOAD.
REQ-007 IDLE: start=1 with cfg_len==0 SHALL go directly to DONE; ld SHALL never be asserted.
REQ-008 LOAD SHALL last exactly one cycle with ld=1, en_cnt=0 and en_tri=0, then go to SHIFT; co is ignored in LOAD.
REQ-009 SHIFT SHALL drive en_cnt=1 and en_tri=1, and SHALL go to DONE on the first cycle co=1 is sampled.
REQ-010 SHIFT SHALL count its own cycles; once the count reaches TO_CYC with co=0, the FSM SHALL go to ERR.
REQ-011 If co=1 and the timeout occur in the same cycle, co SHALL win and the FSM SHALL go to DONE.
REQ-012 DONE SHALL last one cycle with done=1 and all datapath enables 0, then go to IDLE.
REQ-013 ERR SHALL hold err=1 with all datapath enables 0 until clr_err=1, then go to IDLE.
REQ-014 abort=1 in any state SHALL force IDLE on the next edge, with all outputs 0 on that edge and no done pulse.
REQ-015 abort SHALL have priority over start, co, timeout and clr_err.
REQ-016 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-017 Latency from start to ld SHALL be 1 cycle; from a sampled co to done SHALL be 1 cycle.
REQ-018 pi SHALL hold the latched value until the next accepted start; the timeout counter SHALL clear on every entry to SHIFT.

Reset
REQ-019 rst=0 SHALL asynchronously force IDLE, clear the timeout counter, and set pi=0, ld=0, en_cnt=0, en_tri=0, busy=0, done=0, err=0.
REQ-020 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse; operation resumes on the first clk edge after rst deassertion.

Structure
REQ-021 A shared package bufcnt_pkg SHALL hold the state encoding (enumerated type) and the W and TO_CYC defaults.
REQ-022 The timeout counter SHALL be the sub-module bufcnt_tmr (inputs clr and en; output expired), instantiated once.

Verification
REQ-023 cfg_len=8'h0A, start pulse, co=1 on the 10th SHIFT cycle -> ld high 1 cycle, pi=8'h0A, en_cnt/en_tri high 10 cycles, done pulse on the next cycle.
REQ-024 TO_CYC=255, co held 0 -> err=1 after 255 SHIFT cycles; clr_err pulse -> IDLE, err=0.
REQ-025 abort asserted in the 3rd SHIFT cycle -> all outputs 0 on the next edge, no done; a new start is then accepted normally.
REQ-026 cfg_len=0 with start -> done pulse 1 cycle later, ld never asserted.
REQ-027 rst driven low mid-SHIFT, independent of clk -> outputs 0 immediately; a start pulse while busy -> ignored, exactly one done pulse for the transfer.
